// File: rtl/uop_pkg.sv
// Shared definitions for the micro-op sequencer and its ROM neighbourhood.
package uop_pkg;

  localparam int UOP_W  = 8;
  localparam int ROM_AW = 8;

  // ROM word that terminates a routine
  localparam logic [UOP_W-1:0] END_CODE_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    HOLD
  } state_t;

endpackage

// File: rtl/uop_sequencer.sv
// Micro-op sequencer: walks the micro-op ROM from a decoder-supplied entry
// address and hands each fetched micro-op to the execution unit over a
// valid/ready handshake. A routine ends on END_CODE, or aborts once MAX_LEN
// micro-ops have been issued or the address would wrap past 8'hFF.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int unsigned       MAX_LEN  = 16,
  parameter logic [UOP_W-1:0]  END_CODE = END_CODE_DEFAULT
) (
  input  logic              CS,
  input  logic              cen,
  input  logic              req_valid,
  input  logic [ROM_AW-1:0] req_entry,
  output logic              req_ready,
  input  logic              flush,
  output logic [ROM_AW-1:0] add,
  input  logic [UOP_W-1:0]  rom_uop,
  output logic              uop_valid,
  output logic [UOP_W-1:0]  uop_data,
  input  logic              uop_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);

  state_t     state;
  logic [7:0] count;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge CS or negedge cen) begin
    if (!cen) begin
      state       <= IDLE;
      add         <= '0;
      uop_data    <= '0;
      uop_valid   <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
      count       <= '0;
    end else begin
      done        <= 1'b0;
      err_overrun <= 1'b0;
      // flush pre-empts every non-IDLE action, including a same-cycle
      // handshake in HOLD, so that micro-op is treated as not consumed
      if (state != IDLE && flush) begin
        uop_valid <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              add   <= req_entry;
              count <= '0;
              state <= FETCH;
            end
          end
          FETCH: begin
            state <= DECODE;
          end
          DECODE: begin
            if (rom_uop == END_CODE) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              uop_data  <= rom_uop;
              uop_valid <= 1'b1;
              state     <= HOLD;
            end
          end
          HOLD: begin
            if (uop_valid && uop_ready) begin
              uop_valid <= 1'b0;
              count     <= count + 8'd1;
              if ((count + 8'd1) == MAX_LEN_C || add == 8'hFF) begin
                err_overrun <= 1'b1;
                state       <= IDLE;
              end else begin
                add   <= add + 8'd1;
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: table of entry-address routines on the reference
// ROM, hand-written multi-cycle corner sequences, then randomized ROM
// contents and randomized back-pressure checked against a routine-walk model.
module tb_uop_sequencer;

  localparam int unsigned MAX_LEN = 16;

  logic       CS = 1'b0;
  logic       cen = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_entry = '0;
  logic       flush = 1'b0;
  logic       uop_ready = 1'b0;
  logic [7:0] rom_uop;
  logic [7:0] add;
  logic [7:0] uop_data;
  logic       req_ready, uop_valid, busy, done, err_overrun;

  logic [7:0] rom [256];
  int         checks = 0;
  int         failures = 0;
  int         exp_a[$];
  int         exp_d[$];

  uop_sequencer #(.MAX_LEN(MAX_LEN), .END_CODE(8'h00)) dut (
    .CS(CS), .cen(cen),
    .req_valid(req_valid), .req_entry(req_entry), .req_ready(req_ready),
    .flush(flush), .add(add), .rom_uop(rom_uop),
    .uop_valid(uop_valid), .uop_data(uop_data), .uop_ready(uop_ready),
    .busy(busy), .done(done), .err_overrun(err_overrun)
  );

  always #5 CS = ~CS;

  // Uo ROM: registers ROM[add] on every clock edge
  always @(posedge CS) rom_uop <= rom[add];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Routine walk from the rules: list of (address, micro-op) issued, and outcome
  function automatic void model(input logic [7:0] entry, output int n, output bit d, output bit e);
    int a;
    a = int'(entry);
    exp_a.delete(); exp_d.delete();
    n = 0; d = 0; e = 0;
    while (1) begin
      if (rom[a] == 8'h00) begin d = 1; return; end
      exp_a.push_back(a);
      exp_d.push_back(int'(rom[a]));
      n++;
      if (n == int'(MAX_LEN) || a == 255) begin e = 1; return; end
      a++;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_add"}, add, 0);
    chk({tag, "_uop_data"}, uop_data, 0);
    chk({tag, "_uop_valid"}, uop_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_overrun, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Issue one request at a negedge and follow the routine to its end pulse.
  // rnd: random back-pressure; stall_idx: hold ready low 4 cycles on that micro-op.
  task automatic run(input logic [7:0] entry, input bit rnd, input int stall_idx,
                     input bit flush_req, output int n, output bit d, output bit e,
                     output int end_t, output bit ok_sp);
    int t, last, stall_left, mn, first;
    bit md, me, pstall;
    logic [7:0] pd, pa;
    model(entry, mn, md, me);
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_entry = entry; flush = flush_req;
    @(negedge CS);
    req_valid = 1'b0; flush = 1'b0; req_entry = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("add_is_entry", add, entry);
    t = 0; n = 0; d = 0; e = 0; last = -1; first = -1; end_t = -1;
    stall_left = 4; pstall = 0; pd = '0; pa = '0; ok_sp = 1;
    while (t < 2000) begin
      chk("pulse_exclusive", int'(done & err_overrun), 0);
      if (busy && add < entry) chk("add_no_wrap", add, entry);
      if (pstall) begin
        chk("stall_valid_held", uop_valid, 1);
        chk("stall_data_held", uop_data, pd);
        chk("stall_add_held", add, pa);
      end
      if (done) d = 1;
      if (err_overrun) e = 1;
      if (d || e) begin
        end_t = t;
        chk("idle_at_pulse_busy", busy, 0);
        chk("idle_at_pulse_ready", req_ready, 1);
        chk("no_valid_at_pulse", uop_valid, 0);
        break;
      end
      if (rnd) uop_ready = ($urandom_range(0, 3) != 0);
      else if (n == stall_idx && stall_left > 0 && uop_valid) begin
        uop_ready = 1'b0; stall_left--;
      end else uop_ready = 1'b1;
      pstall = 0;
      if (uop_valid) begin
        if (first < 0) begin
          first = t;
          chk("first_valid_latency", t, 2);
        end
        if (uop_ready) begin
          if (n < exp_a.size()) begin
            chk("uop_add", add, exp_a[n]);
            chk("uop_data", uop_data, exp_d[n]);
          end else chk("extra_uop", n, exp_a.size());
          if (last >= 0 && t - last != 3) ok_sp = 0;
          last = t; n++;
        end else begin
          pstall = 1; pd = uop_data; pa = add;
        end
      end
      @(negedge CS);
      t++;
    end
    if (end_t < 0) chk("routine_timeout", t, -1);
    uop_ready = 1'b0;
    chk("model_count", n, mn);
    chk("model_done", d, md);
    chk("model_err", e, me);
    @(negedge CS);
    chk("pulse_one_cycle", int'({done, err_overrun}), 0);
    chk("idle_after_pulse", busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!uop_valid && k < 20) begin @(negedge CS); k++; end
    chk({tag, "_valid_reached"}, uop_valid, 1);
  endtask

  typedef struct {
    logic [7:0] entry;
    int         n;
    bit         d;
    bit         e;
    int         end_t;
  } vec_t;

  vec_t tbl[6];
  int   n, end_t;
  bit   d, e, ok_sp;

  initial begin
    for (int unsigned i = 0; i < 256; i++) rom[i] = (i == 0) ? 8'h00 : 8'h02;
    // ready held high: one micro-op every 3 cycles; err one cycle after last handshake
    tbl[0] = '{8'h00, 0,  1'b1, 1'b0, 2};
    tbl[1] = '{8'h05, 16, 1'b0, 1'b1, 48};
    tbl[2] = '{8'hFA, 6,  1'b0, 1'b1, 18};
    tbl[3] = '{8'hF5, 11, 1'b0, 1'b1, 33};
    tbl[4] = '{8'hF0, 16, 1'b0, 1'b1, 48};
    tbl[5] = '{8'h01, 16, 1'b0, 1'b1, 48};

    // power-on reset
    repeat (2) @(negedge CS);
    check_reset_outputs("por");
    cen = 1'b1;
    @(negedge CS);

    // reset asserted mid-HOLD
    req_valid = 1'b1; req_entry = 8'h05;
    @(negedge CS);
    req_valid = 1'b0;
    wait_valid("rst_hold");
    cen = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge CS);
    cen = 1'b1;
    @(negedge CS);
    chk("rst_no_pulse", int'({done, err_overrun}), 0);
    run(8'h05, 0, -1, 0, n, d, e, end_t, ok_sp);
    chk("rst_rerun_count", n, 16);
    chk("rst_rerun_err", e, 1);

    // table of routines on the reference ROM
    for (int unsigned i = 0; i < 6; i++) begin
      run(tbl[i].entry, 0, -1, 0, n, d, e, end_t, ok_sp);
      chk($sformatf("tbl%0d_count", i), n, tbl[i].n);
      chk($sformatf("tbl%0d_done", i), d, tbl[i].d);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
      chk($sformatf("tbl%0d_end_cycle", i), end_t, tbl[i].end_t);
      chk($sformatf("tbl%0d_spacing", i), ok_sp, 1);
    end

    // back-pressure: ready low 4 cycles on the 2nd micro-op
    run(8'h05, 0, 1, 0, n, d, e, end_t, ok_sp);
    chk("stall_count", n, 16);
    chk("stall_err", e, 1);
    chk("stall_end_cycle", end_t, 52);

    // flush together with a handshake in HOLD
    req_valid = 1'b1; req_entry = 8'h05;
    @(negedge CS);
    req_valid = 1'b0;
    wait_valid("flush_hold");
    uop_ready = 1'b1; flush = 1'b1;
    @(negedge CS);
    uop_ready = 1'b0; flush = 1'b0;
    chk("flush_valid", uop_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_no_pulse", int'({done, err_overrun}), 0);
    chk("flush_add_held", add, 5);
    run(8'hFA, 0, -1, 0, n, d, e, end_t, ok_sp);
    chk("after_flush_count", n, 6);
    chk("after_flush_err", e, 1);

    // flush in FETCH suppresses the END done
    req_valid = 1'b1; req_entry = 8'h00;
    @(negedge CS);
    req_valid = 1'b0; flush = 1'b1;
    @(negedge CS);
    flush = 1'b0;
    chk("flush_fetch_busy", busy, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("flush_fetch_no_done", done, 0);
      @(negedge CS);
    end

    // flush in IDLE does not block the request
    run(8'h05, 0, -1, 1, n, d, e, end_t, ok_sp);
    chk("idle_flush_count", n, 16);

    // random ROM contents and random back-pressure
    for (int unsigned i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int unsigned r = 0; r < 40; r++) begin
      logic [7:0] ent;
      ent = (r < 4) ? 8'(8'hFC + r) : 8'($urandom);
      run(ent, 1, -1, 0, n, d, e, end_t, ok_sp);
      chk("rand_one_outcome", int'(d) + int'(e), 1);
      repeat ($urandom_range(0, 2)) @(negedge CS);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
